// File: rtl/a_writer_pkg.sv
// Shared types and default sizes for the a_writer vector-to-BRAM write engine.
package a_writer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int A_ADDR_W_DEF   = 32;
  localparam int A_DEPTH_DEF    = 32;

endpackage

// File: rtl/a_writer.sv
// Latches a whole A_DEPTH-element vector in one handshake and streams it into BRAM port A,
// one element per cycle from a base address. Optional port stall: define A_WRITER_STALL_EN.
module a_writer
  import a_writer_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int A_ADDR_W    = A_ADDR_W_DEF,
  parameter int A_DEPTH     = A_DEPTH_DEF,
  parameter int INDEX_WIDTH = $clog2(A_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef A_WRITER_STALL_EN
  input  logic                  a_BRAM_stall_i,
`endif
  // Handshake: a vector transfers on a rising edge where a_valid_i && a_ready_o; a_i and
  // base_addr_i are sampled only then. a_ready_o is high exactly while idle.
  input  logic                  a_valid_i,
  output logic                  a_ready_o,
  input  logic [DATA_WIDTH-1:0] a_i [0:A_DEPTH-1],
  input  logic [A_ADDR_W-1:0]   base_addr_i,
  output logic                  a_BRAM_ena,
  output logic                  a_BRAM_wea,
  output logic [A_ADDR_W-1:0]   a_BRAM_addra,
  output logic [DATA_WIDTH-1:0] a_BRAM_dina,
  output logic                  done_o,
  output state_t                dbg_state
);

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(A_DEPTH - 1);

  state_t                 state, state_next;
  logic [INDEX_WIDTH-1:0] idx, idx_next;
  logic [A_ADDR_W-1:0]    base_reg;
  logic [DATA_WIDTH-1:0]  a_reg [0:A_DEPTH-1];
  logic                   load;
  logic                   done_next;
  logic                   stall;

`ifdef A_WRITER_STALL_EN
  assign stall = a_BRAM_stall_i;
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      base_reg <= '0;
      done_o   <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      done_o <= done_next;
      if (load) base_reg <= base_addr_i;
    end
  end

  for (genvar k = 0; k < A_DEPTH; k++) begin : g_vec
    always_ff @(posedge clk) begin
      if (rst)       a_reg[k] <= '0;
      else if (load) a_reg[k] <= a_i[k];
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    done_next  = 1'b0;
    load       = 1'b0;
    a_ready_o  = 1'b0;
    a_BRAM_ena = 1'b0;
    a_BRAM_wea = 1'b0;
    case (state)
      IDLE: begin
        a_ready_o = 1'b1;
        if (a_valid_i) begin
          load       = 1'b1;
          idx_next   = '0;
          state_next = WRITE;
        end
      end
      WRITE: begin
        // A stalled cycle issues nothing and holds idx, so the element is retried intact.
        a_BRAM_ena = ~stall;
        a_BRAM_wea = ~stall;
        if (!stall) begin
          if (idx == LAST_IDX) begin
            idx_next   = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign a_BRAM_addra = base_reg + A_ADDR_W'(idx);
  assign a_BRAM_dina  = a_reg[idx];
  assign dbg_state    = state;

endmodule
